cve2_obi_mem_responder: RTL and testbench

//  Device-side responder for the core instruction/data request interface (req/gnt/rvalid/err).

---
 rtl/cve2_obi_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_cve2_obi_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cve2_obi_mem_responder
// Purpose  : Device-side responder for the core req/gnt/rvalid/err interface.
//            Word-addressed memory behind an in-order response queue, with a
//            runtime grant stall and a minimum response latency so that the
//            core LSU / prefetch paths can be stressed in unit benches.
// Ports    : clk_i        clock
//            rst_ni       asynchronous active-low reset
//            req_i        request valid, held with its payload until gnt_o
//            gnt_o        request accepted this cycle (combinational)
//            addr_i       byte address, bits [1:0] ignored for memory index
//            we_i         1 = write, 0 = read
//            be_i         byte enables for writes
//            wdata_i      write data
//            gnt_stall_i  number of req cycles to stall before granting
//            rvalid_o     response valid, one cycle per granted request
//            rdata_o      read data (0 for writes, errors, idle cycles)
//            err_o        error response (0 when rvalid_o = 0)
// Revision : 1.0 - initial release
// ============================================================================
module cve2_obi_mem_responder #(
  parameter int unsigned Depth          = 16384,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1,
  parameter logic [31:0] ErrAddrBase    = 32'hFFFF_F000,
  parameter logic [31:0] ErrAddrMask    = 32'hFFFF_F000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  gnt_stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam int unsigned LW = $clog2(RespLatency + 1);

  localparam logic [31:0]   DepthWords = 32'(Depth);
  localparam logic [PW-1:0] LastPtr    = PW'(MaxOutstanding - 1);
  localparam logic [CW-1:0] MaxCount   = CW'(MaxOutstanding);
  localparam logic [LW-1:0] AgeMax     = LW'(RespLatency);
  localparam logic [LW-1:0] AgeOne     = LW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]   mem [Depth];

  logic [3:0]    stall_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          q_valid [MaxOutstanding];
  logic          q_err   [MaxOutstanding];
  logic [31:0]   q_rdata [MaxOutstanding];
  logic [LW-1:0] q_age   [MaxOutstanding];

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic [AW-1:0] mem_idx;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [31:0]   push_rdata;
  logic          space;
  logic          push;
  logic          pop;

  assign mem_idx = addr_i[2 +: AW];

  // Out-of-range words and the injected window both return an error.
  assign acc_err = ({2'b00, addr_i[31:2]} >= DepthWords) |
                   ((addr_i & ErrAddrMask) == ErrAddrBase);

  assign rd_word    = mem[mem_idx];
  assign push_rdata = (we_i | acc_err) ? 32'h0 : rd_word;

  // --------------------------------------------------------------------------
  // Grant: the response popped this cycle frees its slot immediately, so a
  // full queue can still accept a request on an rvalid cycle.
  // --------------------------------------------------------------------------
  assign space = (count < MaxCount) | rvalid_o;
  assign gnt_o = rst_ni & req_i & (stall_cnt >= gnt_stall_i) & space;

  assign push = gnt_o;
  assign pop  = rvalid_o;

  // --------------------------------------------------------------------------
  // Response side: driven from queue registers only
  // --------------------------------------------------------------------------
  assign rvalid_o = q_valid[rd_ptr] & (q_age[rd_ptr] >= AgeMax);
  assign rdata_o  = rvalid_o ? q_rdata[rd_ptr] : 32'h0;
  assign err_o    = rvalid_o & q_err[rd_ptr];

  // --------------------------------------------------------------------------
  // Stall counter: saturates so a long-held request never wraps back below
  // the programmed stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= 4'h0;
    end else if (!req_i || gnt_o) begin
      stall_cnt <= 4'h0;
    end else if (stall_cnt != 4'hF) begin
      stall_cnt <= stall_cnt + 4'h1;
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port (contents are intentionally not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response queue. Ages advance first; the pop then clears the head and the
  // push is applied last, so a push into the slot just popped (full queue)
  // takes effect with a fresh age of one.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        q_valid[i] <= 1'b0;
        q_err[i]   <= 1'b0;
        q_rdata[i] <= 32'h0;
        q_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (q_valid[i] && (q_age[i] != AgeMax)) begin
          q_age[i] <= q_age[i] + AgeOne;
        end
      end

      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PW'(1);
      end

      if (push) begin
        q_valid[wr_ptr] <= 1'b1;
        q_err[wr_ptr]   <= acc_err;
        q_rdata[wr_ptr] <= push_rdata;
        q_age[wr_ptr]   <= AgeOne;
        wr_ptr          <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Protocol and structural checks
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_req_payload_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> ($stable(addr_i) && $stable(we_i) &&
                           $stable(be_i) && $stable(wdata_i)));

  a_count_bound : assert property (
    @(posedge clk_i) disable iff (!rst_ni) count <= MaxCount);

  a_rvalid_not_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni) rvalid_o |-> (count != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cve2_obi_mem_responder
// Purpose  : Directed self-checking bench. Instance "dut_a" uses default
//            parameters (latency 1); "dut_b" uses RespLatency = 4 for the
//            backlog and reset-in-flight scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cve2_obi_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A signals
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_be = '0, a_stall = '0;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;

  // instance B signals
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_be = '0, b_stall = '0;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;

  cve2_obi_mem_responder dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt),
    .addr_i(a_addr), .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata),
    .gnt_stall_i(a_stall), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
  );

  cve2_obi_mem_responder #(.MaxOutstanding(2), .RespLatency(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt),
    .addr_i(b_addr), .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata),
    .gnt_stall_i(b_stall), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit use_b, input logic req, input logic we,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    if (use_b) begin
      b_req = req; b_we = we; b_addr = addr; b_be = be; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata;
    end
  endtask

  // One complete transfer. Entered and left at posedge+1. gnt_wait counts
  // req cycles before the granted one; rsp_lat counts cycles from gnt to rvalid.
  task automatic xfer(input bit use_b, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int gnt_wait, output int rsp_lat);
    rdata = '0; err = 1'b0; gnt_wait = 0; rsp_lat = 0;
    drive(use_b, 1'b1, we, addr, be, wdata);
    forever begin
      @(negedge clk);
      if (use_b ? b_gnt : a_gnt) break;
      gnt_wait++;
      if (gnt_wait >= 40) begin
        check_eq("gnt_timeout", 32'(gnt_wait), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(use_b, 1'b0, we, addr, be, wdata);
    forever begin
      @(negedge clk);
      rsp_lat++;
      if (use_b ? b_rvalid : a_rvalid) begin
        rdata = use_b ? b_rdata : a_rdata;
        err   = use_b ? b_err : a_err;
        break;
      end
      if (rsp_lat >= 40) begin
        check_eq("rsp_timeout", 32'(rsp_lat), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          gw, rl;
  int          g_cyc [4];
  int          v_cyc [4];
  logic [31:0] v_dat [4];
  int          ng, nv;

  initial begin
    // ---------------- reset state (request held high during reset) --------
    a_req = 1'b1;
    b_req = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_gnt",    32'(a_gnt), 32'd0);
    check_eq("rst_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("rst_rdata",  a_rdata, 32'h0);
    check_eq("rst_err",    32'(a_err), 32'd0);
    check_eq("rst_gnt_b",  32'(b_gnt), 32'd0);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- basic write / read ----------------------------------
    xfer(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, er, gw, rl);
    check_eq("wr_gnt_wait", 32'(gw), 32'd0);
    check_eq("wr_lat",      32'(rl), 32'd1);
    check_eq("wr_rdata",    rd, 32'h0);
    check_eq("wr_err",      32'(er), 32'd0);
    xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("rd_gnt_wait", 32'(gw), 32'd0);
    check_eq("rd_lat",      32'(rl), 32'd1);
    check_eq("rd_rdata",    rd, 32'hDEADBEEF);
    check_eq("rd_err",      32'(er), 32'd0);
    @(negedge clk);
    check_eq("idle_rvalid", 32'(a_rvalid), 32'd0);
    check_eq("idle_rdata",  a_rdata, 32'h0);
    @(posedge clk); #1;

    // ---------------- byte enables ----------------------------------------
    xfer(0, 1'b1, 32'h40, 4'hF, 32'h11223344, rd, er, gw, rl);
    xfer(0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, rd, er, gw, rl);
    xfer(0, 1'b0, 32'h40, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("be_rdata", rd, 32'h11BB33DD);

    // ---------------- grant stall -----------------------------------------
    a_stall = 4'd3;
    xfer(0, 1'b0, 32'h100, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("stall3_wait",  32'(gw), 32'd3);
    check_eq("stall3_rdata", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h40, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("stall3_again", 32'(gw), 32'd3);

    // stall lowered mid-stall: compared against the current value
    drive(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    check_eq("midstall_c0", 32'(a_gnt), 32'd0);
    @(posedge clk); #1;
    a_stall = 4'd1;
    @(negedge clk);
    check_eq("midstall_c1", 32'(a_gnt), 32'd1);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check_eq("midstall_rv", 32'(a_rvalid), 32'd1);
    check_eq("midstall_rd", a_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    a_stall = 4'd0;

    // ---------------- error responses -------------------------------------
    xfer(0, 1'b0, 32'h0001_0000, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("oor_err",   32'(er), 32'd1);
    check_eq("oor_rdata", rd, 32'h0);
    xfer(0, 1'b0, 32'h0001_0100, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("oor_alias_err",   32'(er), 32'd1);
    check_eq("oor_alias_rdata", rd, 32'h0);
    xfer(0, 1'b1, 32'h0000_F004, 4'hF, 32'hCAFE0001, rd, er, gw, rl);
    check_eq("win_pre_err", 32'(er), 32'd0);
    xfer(0, 1'b1, 32'hFFFF_F004, 4'hF, 32'h5, rd, er, gw, rl);
    check_eq("win_wr_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 32'hFFFF_F004, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("win_rd_err",   32'(er), 32'd1);
    check_eq("win_rd_rdata", rd, 32'h0);
    xfer(0, 1'b0, 32'h0000_F004, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("win_mem_kept", rd, 32'hCAFE0001);

    // ---------------- backlog on latency-4 instance -----------------------
    xfer(1, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, rd, er, gw, rl);
    check_eq("b_wr_lat", 32'(rl), 32'd4);
    xfer(1, 1'b1, 32'h4, 4'hF, 32'hA1A1A1A1, rd, er, gw, rl);
    xfer(1, 1'b1, 32'h8, 4'hF, 32'hA2A2A2A2, rd, er, gw, rl);

    ng = 0; nv = 0;
    drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (b_rvalid && nv < 4) begin v_cyc[nv] = c; v_dat[nv] = b_rdata; nv++; end
      if (b_gnt && ng < 4) begin g_cyc[ng] = c; ng++; end
      @(posedge clk); #1;
      if (ng >= 3) b_req = 1'b0;
      else         b_addr = 32'(ng * 4);
    end
    check_eq("bl_ngnt", 32'(ng), 32'd3);
    check_eq("bl_nrv",  32'(nv), 32'd3);
    check_eq("bl_g0", 32'(g_cyc[0]), 32'd0);
    check_eq("bl_g1", 32'(g_cyc[1]), 32'd1);
    check_eq("bl_g2", 32'(g_cyc[2]), 32'd4);
    check_eq("bl_v0", 32'(v_cyc[0]), 32'd4);
    check_eq("bl_v1", 32'(v_cyc[1]), 32'd5);
    check_eq("bl_v2", 32'(v_cyc[2]), 32'd8);
    check_eq("bl_d0", v_dat[0], 32'hA0A0A0A0);
    check_eq("bl_d1", v_dat[1], 32'hA1A1A1A1);
    check_eq("bl_d2", v_dat[2], 32'hA2A2A2A2);

    // ---------------- reset with two reads in flight ----------------------
    ng = 0;
    drive(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk); if (b_gnt) ng++;
    @(posedge clk); #1; b_addr = 32'h4;
    @(negedge clk); if (b_gnt) ng++;
    @(posedge clk); #1; b_req = 1'b0;
    check_eq("rf_ngnt", 32'(ng), 32'd2);
    rst_n = 1'b0;
    b_req = 1'b1;
    @(negedge clk);
    check_eq("rf_rst_gnt",    32'(b_gnt), 32'd0);
    check_eq("rf_rst_rvalid", 32'(b_rvalid), 32'd0);
    @(posedge clk); #1;
    b_req = 1'b0;
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b_rvalid) nv++;
    end
    check_eq("rf_dropped", 32'(nv), 32'd0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h8, 4'h0, 32'h0, rd, er, gw, rl);
    check_eq("rf_post_wait",  32'(gw), 32'd0);
    check_eq("rf_post_lat",   32'(rl), 32'd4);
    check_eq("rf_post_rdata", rd, 32'hA2A2A2A2);
    check_eq("rf_post_err",   32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
